// File: rtl/source_3_operand_router.sv
// rtl/source_3_operand_router.sv - in-order FIFO steering source-3 operands to per-unit holding registers
// Build option SRC3_HOLD_LAST_EN: out_value keeps the last operand after consume instead of clearing.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module source_3_operand_router #(
  parameter int WORD_SIZE  = `WORD_SIZE,
  parameter int NUM_UNITS  = 3,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SEL_W-1:0]               in_sel,
  input  logic [WORD_SIZE-1:0]           in_value,
  output logic [NUM_UNITS-1:0]           out_valid,
  input  logic [NUM_UNITS-1:0]           out_ready,
  output logic [NUM_UNITS*WORD_SIZE-1:0] out_value,
  output logic                           err_sel,
  output logic [CNT_W-1:0]               fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [SEL_W-1:0]               sel_mem_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]           val_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [NUM_UNITS-1:0]           out_valid_q, out_valid_d;
  logic [NUM_UNITS*WORD_SIZE-1:0] out_value_q, out_value_d;
  logic                           err_sel_q, err_sel_d;
  logic                           push, pop, head_legal, head_go;
  logic [SEL_W-1:0]               head_sel;
  logic [WORD_SIZE-1:0]           head_val;

  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign head_sel   = sel_mem_q[rd_ptr_q];
  assign head_val   = val_mem_q[rd_ptr_q];
  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign err_sel    = err_sel_q;
  assign fifo_count = count_q;

  always_comb begin
    head_legal  = (int'(head_sel) < NUM_UNITS);
    head_go     = 1'b0;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head_sel == SEL_W'(u) && (!out_valid_q[u] || out_ready[u])) head_go = 1'b1;
    end
    // Illegal selects are dropped at the head so they never block the queue.
    pop       = (count_q != '0) && (!head_legal || head_go);
    err_sel_d = (count_q != '0) && !head_legal;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (pop && head_sel == SEL_W'(u)) begin
        out_valid_d[u] = 1'b1;
        out_value_d[u*WORD_SIZE +: WORD_SIZE] = head_val;
      end else if (out_valid_q[u] && out_ready[u]) begin
        out_valid_d[u] = 1'b0;
`ifndef SRC3_HOLD_LAST_EN
        out_value_d[u*WORD_SIZE +: WORD_SIZE] = '0;
`endif
      end
    end
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= '0;
      out_value_q <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      err_sel_q   <= err_sel_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      sel_mem_q[wr_ptr_q] <= in_sel;
      val_mem_q[wr_ptr_q] <= in_value;
    end
  end

endmodule

// File: tb/tb_source_3_operand_router.sv
// tb/tb_source_3_operand_router.sv - scoreboard bench for source_3_operand_router
// Per-unit expected queues are filled on accepted pushes and drained on consumes.
module tb_source_3_operand_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_value;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [95:0] out_value;
  logic        err_sel;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  int pending_err = 0;
  logic [31:0] q0[$], q1[$], q2[$];

  source_3_operand_router #(
    .WORD_SIZE(32), .NUM_UNITS(3), .SEL_W(2), .FIFO_DEPTH(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_value(in_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value), .err_sel(err_sel),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] val);
    in_valid = 1'b1;
    in_sel   = sel;
    in_value = val;
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      pending_err = 0;
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (out_valid[u] && out_ready[u]) begin
          logic [31:0] ev;
          logic        have;
          have = 1'b0;
          ev   = '0;
          if (u == 0 && q0.size() > 0) begin ev = q0.pop_front(); have = 1'b1; end
          if (u == 1 && q1.size() > 0) begin ev = q1.pop_front(); have = 1'b1; end
          if (u == 2 && q2.size() > 0) begin ev = q2.pop_front(); have = 1'b1; end
          check($sformatf("u%0d_expected_present", u), 96'(have), 96'(1));
          if (have) check($sformatf("u%0d_value", u), 96'(out_value[u*32 +: 32]), 96'(ev));
        end
      end
      if (err_sel) begin
        check("err_sel_expected", 96'(pending_err > 0), 96'(1));
        if (pending_err > 0) pending_err--;
      end
      if (in_valid && in_ready) begin
        case (in_sel)
          2'd0: q0.push_back(in_value);
          2'd1: q1.push_back(in_value);
          2'd2: q2.push_back(in_value);
          default: pending_err++;
        endcase
      end
    end
  end

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (i < 50 && !(fifo_count == 0 && out_valid == 0)) begin
      tick();
      i++;
    end
    check(tag, 96'(fifo_count == 0 && out_valid == 0), 96'(1));
  endtask

  initial begin
    logic [31:0] hold_exp;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_value = '0; out_ready = '0;
    tick(); tick();
    check("rst_in_ready", 96'(in_ready), 96'(1));
    check("rst_count", 96'(fifo_count), 96'(0));
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_out_value", out_value, 96'(0));
    check("rst_err_sel", 96'(err_sel), 96'(0));
    rst = 1'b0;
    tick();

    // Single operand to unit 2
    out_ready = 3'b111;
    drive(2'd2, 32'hDEADBEEF);
    check("single_count_after_accept", 96'(fifo_count), 96'(1));
    check("single_no_early_valid", 96'(out_valid), 96'(0));
    tick();
    check("single_out_valid", 96'(out_valid), 96'(3'b100));
    check("single_out_value", 96'(out_value[95:64]), 96'(32'hDEADBEEF));
    tick();
    check("single_count_zero", 96'(fifo_count), 96'(0));
    check("single_consumed", 96'(out_valid), 96'(0));
`ifdef SRC3_HOLD_LAST_EN
    hold_exp = 32'hDEADBEEF;
`else
    hold_exp = 32'h0;
`endif
    check("single_value_after_consume", 96'(out_value[95:64]), 96'(hold_exp));

    // Back-pressure fill of unit 0
    out_ready = 3'b000;
    for (int i = 0; i < 5; i++) drive(2'd0, 32'hA0 + 32'(i));
    check("bp_count_full", 96'(fifo_count), 96'(4));
    check("bp_in_ready_low", 96'(in_ready), 96'(0));
    drive(2'd0, 32'hBAD);
    check("bp_sixth_rejected", 96'(fifo_count), 96'(4));
    check("bp_head_value", 96'(out_value[31:0]), 96'(32'hA0));
    out_ready = 3'b001;
    drain("bp_drain_done");

    // Head-of-line blocking
    out_ready = 3'b000;
    drive(2'd1, 32'h11);
    tick();
    drive(2'd1, 32'h22);
    drive(2'd0, 32'h33);
    tick(); tick();
    check("hol_stalled_valid", 96'(out_valid), 96'(3'b010));
    check("hol_stalled_count", 96'(fifo_count), 96'(2));
    check("hol_stalled_value", 96'(out_value[63:32]), 96'(32'h11));
    out_ready = 3'b011;
    tick();
    check("hol_second_valid", 96'(out_valid), 96'(3'b010));
    check("hol_second_value", 96'(out_value[63:32]), 96'(32'h22));
    tick();
    check("hol_third_valid", 96'(out_valid), 96'(3'b001));
    check("hol_third_value", 96'(out_value[31:0]), 96'(32'h33));
    drain("hol_drain_done");

    // Illegal select
    out_ready = 3'b111;
    drive(2'd3, 32'h5555);
    check("ill_count_one", 96'(fifo_count), 96'(1));
    check("ill_no_err_yet", 96'(err_sel), 96'(0));
    tick();
    check("ill_err_pulse", 96'(err_sel), 96'(1));
    check("ill_no_valid", 96'(out_valid), 96'(0));
    check("ill_count_zero", 96'(fifo_count), 96'(0));
    tick();
    check("ill_err_one_cycle", 96'(err_sel), 96'(0));

    // Round-robin stream, one dispatch per cycle
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 3);
      in_value = $urandom;
      tick();
      check("rr_count_le1", 96'(fifo_count <= 3'd1), 96'(1));
    end
    in_valid = 1'b0;
    drain("rr_drain_done");

    // Mid-operation reset
    out_ready = 3'b000;
    drive(2'd0, 32'hC0);
    drive(2'd1, 32'hC1);
    drive(2'd0, 32'hC2);
    drive(2'd0, 32'hC3);
    drive(2'd0, 32'hC4);
    check("mid_count3", 96'(fifo_count), 96'(3));
    check("mid_valid011", 96'(out_valid), 96'(3'b011));
    rst = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2; in_value = 32'hFFFF;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_count", 96'(fifo_count), 96'(0));
    check("mid_rst_valid", 96'(out_valid), 96'(0));
    check("mid_rst_value", out_value, 96'(0));
    check("mid_rst_in_ready", 96'(in_ready), 96'(1));
    tick(); tick();
    check("post_rst_idle_valid", 96'(out_valid), 96'(0));

    check("end_q0_empty", 96'(q0.size()), 96'(0));
    check("end_q1_empty", 96'(q1.size()), 96'(0));
    check("end_q2_empty", 96'(q2.size()), 96'(0));
    check("end_err_pending", 96'(pending_err), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
